// File: rtl/irq_sched_pkg.sv
// Shared constants and types for the interrupt scheduler front-end.
package irq_sched_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        WAIT    = 2'd2
    } sched_state_e;

    // Word offsets inside the 16-word register window
    localparam logic [3:0] OFF_MODE     = 4'd0;
    localparam logic [3:0] OFF_ENABLE   = 4'd1;
    localparam logic [3:0] OFF_PENDING  = 4'd2;
    localparam logic [3:0] OFF_INFLIGHT = 4'd3;
    localparam logic [3:0] OFF_TIMEDOUT = 4'd4;

    localparam int unsigned WIN_WORDS = 16;

    // EIB ISR-clear word address; a write here carrying the in-flight bit acknowledges it
    localparam logic [31:0] EIB_ISR_CLEAR_ADDR = 32'hfffffffe;

endpackage

// File: rtl/irq_scheduler_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr_i,
// wrapping at N. Returns the one-hot grant and its index.
module rr_pick
    import irq_sched_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          valid_o
);

    // Walk the requests starting at the pointer; the first hit wins
    always_comb begin : pick
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        sum         = '0;
        idx         = '0;
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!valid_o && req_i[idx]) begin
                valid_o      = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// Interrupt front-end: synchronizes and conditions raw sources, latches them as
// pending and hands exactly one at a time to the EIB, rotating priority.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing in flight; grant next pending line if any
// DELIVER | irq pulses the in-flight line for one cycle; timer loads
// WAIT    | wait for ISR-clear write of the in-flight line or timeout
module irq_scheduler
    import irq_sched_pkg::*;
#(
    parameter int unsigned IRQ_COUNT   = 32,
    parameter logic [31:0] BASE        = 32'hfffff400,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 strobe,
    input  logic                 rw,
    input  logic [31:0]          addr,
    inout  wire  [31:0]          data,
    input  logic [IRQ_COUNT-1:0] src,
    output logic [IRQ_COUNT-1:0] irq,
    output logic                 busy
);

    localparam int unsigned PW = $clog2(IRQ_COUNT);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    // Synchronizer and conditioning pipeline
    logic [SYNC_STAGES-1:0][IRQ_COUNT-1:0] sync_q;
    logic [IRQ_COUNT-1:0] src_s;
    logic [IRQ_COUNT-1:0] prev_q;
    logic [IRQ_COUNT-1:0] set_d, set_q;

    // Configuration and status
    logic [IRQ_COUNT-1:0] mode_q, enable_q;
    logic [IRQ_COUNT-1:0] pending_d, pending_q;
    logic [IRQ_COUNT-1:0] timedout_d, timedout_q;
    logic [IRQ_COUNT-1:0] inflight_d, inflight_q;

    // Scheduler
    sched_state_e         state_d, state_q;
    logic [PW-1:0]        ptr_d, ptr_q;
    logic [CW-1:0]        cnt_d, cnt_q;
    logic [IRQ_COUNT-1:0] grant_clr;
    logic [IRQ_COUNT-1:0] to_set;
    logic [IRQ_COUNT-1:0] pick_grant;
    logic [PW-1:0]        pick_idx;
    logic                 pick_valid;
    logic                 ack;

    // Bus decode
    logic [31:0]          offset;
    logic                 in_win;
    logic                 wr_win, rd_win;
    logic [3:0]           off4;
    logic [IRQ_COUNT-1:0] wdata;
    logic [31:0]          rsel;
    logic [31:0]          rdata_q;

    assign offset = addr - BASE;
    assign in_win = (offset < 32'(WIN_WORDS));
    assign off4   = offset[3:0];
    assign wr_win = strobe && rw && in_win;
    assign rd_win = strobe && !rw && in_win;
    assign wdata  = data[IRQ_COUNT-1:0];

    assign data = rd_win ? rdata_q : 'z;

    assign ack = strobe && rw && (addr == EIB_ISR_CLEAR_ADDR) &&
                 (|(wdata & inflight_q));

    assign src_s = sync_q[SYNC_STAGES-1];

    // Edge mode fires on a synchronized 0->1; level mode fires every high cycle
    assign set_d = enable_q & ((mode_q & src_s & ~prev_q) | (~mode_q & src_s));

    // Synchronizer chain, edge history and registered set pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
            set_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
            prev_q <= src_s;
            set_q  <= set_d;
        end
    end

    // MODE and ENABLE configuration registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= '0;
            enable_q <= '0;
        end else if (wr_win) begin
            if (off4 == OFF_MODE)   mode_q   <= wdata;
            if (off4 == OFF_ENABLE) enable_q <= wdata;
        end
    end

    // Pending and timed-out bits: a same-cycle set always beats a clear
    always_comb begin
        pending_d  = pending_q & ~grant_clr;
        timedout_d = timedout_q;
        if (wr_win && off4 == OFF_PENDING)  pending_d  = pending_d & ~wdata;
        if (wr_win && off4 == OFF_TIMEDOUT) timedout_d = timedout_d & ~wdata;
        pending_d  = pending_d | set_q;
        timedout_d = timedout_d | to_set;
    end

    // Status register state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q  <= '0;
            timedout_q <= '0;
        end else begin
            pending_q  <= pending_d;
            timedout_q <= timedout_d;
        end
    end

    rr_pick #(
        .N  (IRQ_COUNT),
        .PW (PW)
    ) u_pick (
        .req_i       (pending_q),
        .ptr_i       (ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx),
        .valid_o     (pick_valid)
    );

    // Scheduler next state, grant bookkeeping, timer and outputs
    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_clr  = '0;
        to_set     = '0;
        irq        = '0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    inflight_d = pick_grant;
                    grant_clr  = pick_grant;
                    ptr_d      = (pick_idx == PW'(IRQ_COUNT - 1)) ? '0 : pick_idx + PW'(1);
                    state_d    = DELIVER;
                end
            end
            DELIVER: begin
                irq     = inflight_q;
                busy    = 1'b1;
                cnt_d   = CW'(TIMEOUT);
                state_d = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (ack) begin
                    inflight_d = '0;
                    state_d    = IDLE;
                end else if (cnt_q <= CW'(1)) begin
                    // Counter reaches zero this cycle: abandon and flag the line
                    to_set     = inflight_q;
                    inflight_d = '0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                inflight_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Registered read data, selected at the edge that samples the read
    always_comb begin
        rsel = '0;
        case (off4)
            OFF_MODE:     rsel = 32'(mode_q);
            OFF_ENABLE:   rsel = 32'(enable_q);
            OFF_PENDING:  rsel = 32'(pending_q);
            OFF_INFLIGHT: rsel = 32'(inflight_q);
            OFF_TIMEDOUT: rsel = 32'(timedout_q);
            default:      rsel = '0;
        endcase
    end

    // Read data capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (rd_win) begin
            rdata_q <= rsel;
        end
    end

endmodule

// File: tb/tb_irq_scheduler.sv
module tb_irq_scheduler;

    localparam logic [31:0] BASE    = 32'hfffff400;
    localparam logic [31:0] ISR_CLR = 32'hfffffffe;

    logic        clk;
    logic        reset_n;
    logic        strobe;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] src;
    logic [31:0] irq;
    logic        busy;
    tri1  [31:0] data;
    logic [31:0] drv_data;
    logic        drv_en;

    int checks;
    int errors;

    assign data = drv_en ? drv_data : 'z;

    irq_scheduler #(
        .IRQ_COUNT   (32),
        .BASE        (BASE),
        .SYNC_STAGES (2),
        .TIMEOUT     (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (strobe),
        .rw      (rw),
        .addr    (addr),
        .data    (data),
        .src     (src),
        .irq     (irq),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        strobe   = 1'b1;
        rw       = 1'b1;
        addr     = a;
        drv_data = d;
        drv_en   = 1'b1;
        tick();
        strobe = 1'b0;
        rw     = 1'b0;
        drv_en = 1'b0;
        addr   = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        strobe = 1'b1;
        rw     = 1'b0;
        addr   = a;
        tick();
        d      = data;
        strobe = 1'b0;
        addr   = '0;
    endtask

    task automatic wait_irq(input int budget, output logic found, output logic [31:0] got);
        found = 1'b0;
        got   = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (irq !== 32'h0) begin
                found = 1'b1;
                got   = irq;
                break;
            end
        end
    endtask

    // One cycle to leave DELIVER, then the ISR-clear write lands in WAIT
    task automatic ack(input logic [31:0] m);
        tick();
        bus_write(ISR_CLR, m);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        tick(); tick(); tick();
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL reset_irq got %h want 0", irq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (data !== 32'hffffffff) begin errors++; $display("FAIL reset_data_z got %h want released bus", data); end
        reset_n = 1'b1;
        tick();
        for (int o = 0; o < 5; o++) begin
            bus_read(BASE + 32'(o), v);
            checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", o, v); end
        end
    endtask

    task automatic test_single_edge();
        logic [31:0] v;
        logic [31:0] exp_irq;
        bus_write(BASE + 32'd1, 32'hffffffff);
        bus_write(BASE + 32'd0, 32'hffffffff);
        tick();
        src[3] = 1'b1;
        tick();
        src[3] = 1'b0;
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL edge_lat k1 got %h want 0", irq); end
        for (int k = 2; k <= 6; k++) begin
            if (k == 5) begin
                strobe = 1'b1; rw = 1'b0; addr = BASE + 32'd2;
            end
            tick();
            if (k == 5) begin
                v = data;
                strobe = 1'b0; addr = '0;
                checks++; if (v !== 32'h8) begin errors++; $display("FAIL edge_pending got %h want 8", v); end
            end
            exp_irq = (k == 5) ? 32'h8 : 32'h0;
            checks++; if (irq !== exp_irq) begin errors++; $display("FAIL edge_lat k%0d got %h want %h", k, irq, exp_irq); end
            if (k >= 5) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL edge_busy k%0d got %b want 1", k, busy); end
            end
        end
        bus_read(BASE + 32'd3, v);
        checks++; if (v !== 32'h8) begin errors++; $display("FAIL edge_inflight got %h want 8", v); end
        bus_write(ISR_CLR, 32'h8);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_ack_busy got %b want 0", busy); end
        bus_read(BASE + 32'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL edge_inflight_after got %h want 0", v); end
    endtask

    task automatic test_rotation();
        logic        found;
        logic [31:0] got;
        logic [31:0] exp_seq [5] = '{32'h1, 32'h20, 32'h80000000, 32'h1, 32'h20};
        apply_reset();
        bus_write(BASE + 32'd1, 32'hffffffff);
        bus_write(BASE + 32'd0, 32'hffffffff);
        src = 32'h80000021;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                src = 32'h0;
                tick(); tick(); tick(); tick();
                src = 32'h21;
            end
            wait_irq(30, found, got);
            checks++; if (got !== exp_seq[i]) begin errors++; $display("FAIL rotation_%0d got %h want %h", i, got, exp_seq[i]); end
            ack(exp_seq[i]);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rotation_ack_%0d busy got %b want 0", i, busy); end
        end
        src = 32'h0;
        tick(); tick(); tick(); tick(); tick();
    endtask

    task automatic test_level();
        logic        found;
        logic [31:0] got;
        logic [31:0] v;
        bus_write(BASE + 32'd1, 32'h80);
        bus_write(BASE + 32'd0, 32'hffffff7f);
        src[7] = 1'b1;
        wait_irq(30, found, got);
        checks++; if (got !== 32'h80) begin errors++; $display("FAIL level_first got %h want 80", got); end
        ack(32'h80);
        wait_irq(30, found, got);
        checks++; if (got !== 32'h80) begin errors++; $display("FAIL level_repeat got %h want 80", got); end
        src[7] = 1'b0;
        tick(); tick(); tick();
        bus_write(BASE + 32'd2, 32'h80);
        bus_write(ISR_CLR, 32'h80);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL level_ack_busy got %b want 0", busy); end
        wait_irq(20, found, got);
        checks++; if (got !== 32'h0) begin errors++; $display("FAIL level_stop got %h want 0", got); end
        bus_read(BASE + 32'd2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL level_pending got %h want 0", v); end
    endtask

    task automatic test_timeout();
        logic        found;
        logic [31:0] got;
        logic [31:0] v;
        logic        exp_busy;
        bus_write(BASE + 32'd1, 32'h4);
        bus_write(BASE + 32'd0, 32'hffffffff);
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        wait_irq(30, found, got);
        checks++; if (got !== 32'h4) begin errors++; $display("FAIL timeout_irq got %h want 4", got); end
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_busy = (k <= 8);
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL timeout_busy k%0d got %b want %b", k, busy, exp_busy); end
        end
        bus_read(BASE + 32'd4, v);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL timeout_flag got %h want 4", v); end
        bus_read(BASE + 32'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL timeout_inflight got %h want 0", v); end
        bus_write(BASE + 32'd4, 32'h4);
        bus_read(BASE + 32'd4, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL timeout_w1c got %h want 0", v); end
    endtask

    task automatic test_set_beats_clear();
        logic        found;
        logic [31:0] got;
        logic [31:0] v;
        bus_write(BASE + 32'd1, 32'h14);
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        wait_irq(30, found, got);
        checks++; if (got !== 32'h4) begin errors++; $display("FAIL sbc_irq got %h want 4", got); end
        src[4] = 1'b1;
        tick();
        src[4] = 1'b0;
        tick();
        tick();
        bus_write(BASE + 32'd2, 32'h10);
        bus_read(BASE + 32'd2, v);
        checks++; if (v !== 32'h10) begin errors++; $display("FAIL sbc_pending got %h want 10", v); end
        tick(); tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sbc_last_wait busy got %b want 1", busy); end
        bus_write(ISR_CLR, 32'h4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sbc_ack_busy got %b want 0", busy); end
        bus_read(BASE + 32'd4, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL sbc_timedout got %h want 0", v); end
        checks++; if (irq !== 32'h10) begin errors++; $display("FAIL sbc_next_irq got %h want 10", irq); end
        ack(32'h10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sbc_ack2_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_in_wait();
        logic        found;
        logic [31:0] got;
        logic [31:0] v;
        bus_write(BASE + 32'd1, 32'h6);
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        wait_irq(30, found, got);
        checks++; if (got !== 32'h4) begin errors++; $display("FAIL rst_first got %h want 4", got); end
        for (int k = 0; k < 10; k++) tick();
        src = 32'h6;
        tick();
        src = 32'h0;
        wait_irq(30, found, got);
        checks++; if (got !== 32'h2) begin errors++; $display("FAIL rst_rotate got %h want 2", got); end
        tick();
        reset_n = 1'b0;
        tick();
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL rst_wait_irq got %h want 0", irq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy got %b want 0", busy); end
        reset_n = 1'b1;
        for (int o = 0; o < 5; o++) begin
            bus_read(BASE + 32'(o), v);
            checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_wait_reg%0d got %h want 0", o, v); end
        end
        wait_irq(12, found, got);
        checks++; if (got !== 32'h0) begin errors++; $display("FAIL rst_no_delivery got %h want 0", got); end
        bus_write(BASE + 32'd9, 32'hffffffff);
        bus_read(BASE + 32'd9, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", v); end
        bus_read(BASE + 32'd16, v);
        checks++; if (v !== 32'hffffffff) begin errors++; $display("FAIL outside_window got %h want released bus", v); end
        checks++; if (data !== 32'hffffffff) begin errors++; $display("FAIL idle_data_z got %h want released bus", data); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        strobe   = 1'b0;
        rw       = 1'b0;
        addr     = '0;
        src      = '0;
        drv_data = '0;
        drv_en   = 1'b0;
        test_reset();
        test_single_edge();
        test_rotation();
        test_level();
        test_timeout();
        test_set_beats_clear();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_scheduler.md
Name: irq_scheduler

Overview:
- Front-end interrupt controller between raw peripheral interrupt sources and the external interrupt block's `irq` input.
- Synchronizes and conditions each source (edge or level) and latches it as pending.
- Delivers exactly one interrupt at a time to the EIB, picked by rotating priority.
- Holds off the next delivery until the ISR-clear write for the in-flight line is seen on the bus, or until a timeout expires.

Parameters:
- IRQ_COUNT, 32: number of sources; must equal the EIB irq width.
- BASE, 32'hfffff400: base word address of the register window; must not overlap the EIB stack, trampoline or 0xfffffffd-0xffffffff.
- SYNC_STAGES, 2: synchronizer flops per source; minimum 2.
- TIMEOUT, 1024: cycles to wait for acknowledge before abandoning a delivery; minimum 2.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset: synchronous, active-low.
- strobe  input  1  bus cycle valid.
- rw  input  1  1 = write, 0 = read.
- addr  input  32  bus word address.
- data  inout  32  bus data; driven only during reads of own window, else high-Z.
- src  input  IRQ_COUNT  raw asynchronous interrupt sources.
- irq  output  IRQ_COUNT  one-hot delivery pulse to the EIB irq input.
- busy  output  1  high while a delivery is awaiting acknowledge.

Behaviour:

Reset (reset_n low at a clk edge):
- All registers, pending bits and synchronizer flops clear.
- State returns to IDLE; rotation pointer returns to 0.
- irq = 0, busy = 0, data = high-Z.
- Reset during WAIT abandons the delivery silently.

Register window, word addresses:
- BASE+0 MODE: RW; per-bit 1 = rising-edge, 0 = level.
- BASE+1 ENABLE: RW.
- BASE+2 PENDING: R; write-1-to-clear.
- BASE+3 INFLIGHT: R; one-hot, 0 when idle.
- BASE+4 TIMEDOUT: R sticky; write-1-to-clear.
- Unmapped offsets in BASE..BASE+15: read 0, writes ignored.

Bus timing:
- Reads are registered: rdata is captured at the clk edge where strobe && in-window && !rw.
- data = rdata while strobe && in-window && !rw, else high-Z. This matches EIB read timing.

Conditioning, per source, after synchronization:
- Edge mode: pending bit set on a 0->1 transition.
- Level mode: pending bit set every cycle the source is high.
- Only enabled sources set pending.
- Set beats any same-cycle clear (W1C or grant).

Scheduler FSM, states IDLE / DELIVER / WAIT:
- IDLE: if any pending bit is set, grant the first set bit searching upward from the rotation pointer, wrapping at IRQ_COUNT.
  - Capture the grant in INFLIGHT.
  - Clear that pending bit.
  - Pointer becomes grant+1 mod IRQ_COUNT.
  - Go to DELIVER.
- DELIVER: irq = INFLIGHT for exactly this one cycle; busy = 1; load timeout counter = TIMEOUT; go to WAIT.
- WAIT: busy = 1; irq = 0.
  - Acknowledge is strobe && rw && addr == 32'hfffffffe && (data & INFLIGHT) != 0. On acknowledge: INFLIGHT = 0, go to IDLE.
  - Otherwise the counter decrements. On reaching 0: set the TIMEDOUT bit for that line, clear INFLIGHT, go to IDLE.
  - Acknowledge and expiry in the same cycle: acknowledge wins; no TIMEDOUT.
- Earliest next grant is the cycle after returning to IDLE. Minimum issue interval is 3 cycles.

Other rules:
- Disabling a source clears neither its pending bit nor an in-flight delivery.
- A level source still high after acknowledge re-pends and is delivered again.
- MODE or ENABLE writes take effect the cycle after the write edge.

Decomposition:
- Shared package `irq_sched_pkg`:
  - State encoding constants IDLE/DELIVER/WAIT.
  - Register offset constants MODE/ENABLE/PENDING/INFLIGHT/TIMEDOUT.
  - EIB ISR-clear address constant 32'hfffffffe.
- One sub-module: `rr_pick`, a combinational rotating-priority one-hot picker (pending vector, pointer -> grant, valid).

Test Plan:
1. Reset, ENABLE=1, MODE=1 (edge), pulse src[3] for 1 cycle -> pending[3] set; irq = 32'h8 for exactly one cycle, 2+SYNC_STAGES+1 cycles after the pulse; busy high; write 32'h8 to 0xfffffffe -> busy low next cycle, INFLIGHT reads 0.
2. ENABLE=all, src[0], src[5] and src[31] rise together -> grants 0, 5, 31 in order, each after its acknowledge; then src[0] and src[5] again -> grants 0, 5 (pointer wrapped past 31 to 0).
3. Level mode on src[7] held high, acknowledge each delivery -> repeated deliveries of 32'h80; drop src[7] -> no further delivery after the in-flight one completes.
4. TIMEOUT=8, deliver src[2], never acknowledge -> busy drops 8 cycles after DELIVER; TIMEDOUT reads 32'h4; write 32'h4 to BASE+4 -> reads 0.
5. Edge on src[4] in the same cycle as a W1C of pending[4] -> pending[4] remains 1. Acknowledge coinciding with the counter reaching 0 -> TIMEDOUT stays 0.
6. Assert reset_n low during WAIT -> irq=0, busy=0, all registers 0 on the next cycle. Read of BASE+9 returns 0. data is high-Z when strobe is low.
